cmos_pixel_capture: RTL
=======================

# cmos_pixel_capture

Camera-side capture front end. It takes the raw OV5640 DVP byte stream (vsync, href, 8-bit data) in the camera pixel-clock domain and assembles byte pairs into RGB565 pixels with x/y coordinates and frame/line markers. It skips the unstable frames that follow sensor configuration and flags malformed lines and frames. It sits between `ov5640_top`'s DVP pins and the future frame-buffer writer.

## Interface
Parameters:
- `H_RES`, 1280: active pixels per line.
- `V_RES`, 720: active lines per frame.
- `SKIP_FRAMES`, 10: complete frames discarded after `I_cfg_done` rises; range 0–255.

Ports:
- `I_pxl_clk` in 1: camera pixel clock (`cmos_pclk`); the only clock.
- `I_rst` in 1: asynchronous, active-high reset.
- `I_cfg_done` in 1: sensor configuration complete. It is a level from another domain and is two-flop synchronised internally.
- `I_vsync` in 1: frame sync, active-high pulse between frames.
- `I_href` in 1: line valid, high during active bytes.
- `I_data` in 8: DVP byte.
- `O_pix_valid` out 1: one-cycle strobe per assembled pixel.
- `O_pix_data` out 16: RGB565 value, R[15:11] G[10:5] B[4:0].
- `O_x` out 12: column of current pixel, 0..H_RES-1.
- `O_y` out 12: row of current pixel, 0..V_RES-1.
- `O_sof` out 1: high with the pixel at x=0, y=0.
- `O_eol` out 1: high with the pixel at x=H_RES-1.
- `O_active` out 1: high while in state CAPTURE.
- `O_err_line` out 1: one-cycle pulse for a bad line.
- `O_err_frame` out 1: one-cycle pulse for a bad frame.
- `O_frame_cnt` out 16: completed frames; increments in CAPTURE only and wraps at 16'hFFFF→0.

## Operation
- Input stage: `I_vsync`, `I_href` and `I_data` are registered once. All edge detection uses these registered copies.
- Frame boundary: a rising edge of registered vsync (`vs_rise`).
- States:
  - WAIT_CFG: leave when synchronised cfg_done=1.
  - SKIP: count `vs_rise` events. Go to CAPTURE after SKIP_FRAMES of them. With SKIP_FRAMES=0, the first `vs_rise` goes directly to CAPTURE.
  - CAPTURE: normal operation.
  - Synchronised cfg_done falling in any state returns to WAIT_CFG and clears the skip counter.
- Byte packing: a phase bit toggles on each byte with href=1.
  - Phase 0 stores the high byte.
  - Phase 1 forms {high, low} and emits a pixel.
  - The phase bit clears on every href rising edge and every `vs_rise`.
- Pixels are emitted only in CAPTURE and only while x<H_RES and y<V_RES. Excess pixels and lines are dropped silently, but still counted for error checks.
- x counter: clears on href rise; increments per assembled pixel. Internal count saturates at 4095.
- y counter: clears on `vs_rise`; increments on href fall; saturates at 4095.
- `O_err_line`, on href fall in CAPTURE, fires if either holds:
  - the pixel count is not H_RES;
  - the phase bit is 1 (odd byte count; the partial pixel is discarded).
- `O_err_frame`, on `vs_rise` in CAPTURE, fires if the line count of the frame just ended is not V_RES. The first `vs_rise` after entering CAPTURE performs no check.
- `O_frame_cnt` increments on every `vs_rise` in CAPTURE except that first one.
- Simultaneous `vs_rise` and href fall: the line is closed first (y increment, line check), then the frame check is made, then y clears.

## Timing
- Latency: a low byte present on `I_data` at clock edge t produces `O_pix_valid`=1 and the data in the cycle after edge t+1, i.e. 2 cycles.
- `O_x`, `O_y`, `O_sof` and `O_eol` are aligned with `O_pix_valid`. They hold their values between strobes.
- Error pulses are asserted 2 cycles after the sampling edge of the href/vsync transition.
- Maximum throughput is one pixel per 2 clocks, with no back-pressure.
- Reset values: all outputs 0, state WAIT_CFG, every counter 0, phase 0.
- Reset asserted mid-line drops any partial pixel. After release, capture resumes only through WAIT_CFG/SKIP.

## Structure
- Package `cmos_capture_pkg`:
  - state enum {WAIT_CFG, SKIP, CAPTURE};
  - `PIX_W`=16, `CNT_W`=12, `FCNT_W`=16;
  - RGB565 field positions.
- Sub-module `dvp_byte_packer`: input register, phase bit and 16-bit assembly. It outputs pixel strobe, data, href/vsync edge pulses and an odd-byte flag.
- The top contains the FSM, counters and checks.

## Test plan
- cfg_done=1, SKIP_FRAMES=2, three frames of 1280×720: no `O_pix_valid` during the first two frames. Third frame gives exactly 921600 strobes, first with `O_sof`=1 at (0,0), last at (1279,719) with `O_eol`=1, no errors.
- Bytes 8'hF8 then 8'h1F: `O_pix_data`=16'hF81F exactly 2 cycles after the second byte.
- Line of 2561 bytes: `O_err_line` pulse at href fall; 1280 pixels emitted; next line starts at phase 0.
- Frame of 719 lines: `O_err_frame` pulse at next `vs_rise`; `O_frame_cnt` still increments.
- Line of 1300 pixels: only x=0..1279 emitted; `O_err_line`=1.
- `I_rst` pulse mid-line during CAPTURE: all outputs 0 next cycle; the block waits for cfg_done and SKIP_FRAMES frames again before emitting pixels.

Source files
------------

// File: rtl/cmos_capture_pkg.sv
// rtl/cmos_capture_pkg.sv - shared types and widths for the DVP pixel capture front end
package cmos_capture_pkg;

  typedef enum logic [1:0] {WAIT_CFG, SKIP, CAPTURE} state_t;

  localparam int PIX_W  = 16;
  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

endpackage

// File: rtl/dvp_byte_packer.sv
// rtl/dvp_byte_packer.sv - registers the DVP pins, pairs bytes into RGB565 words, flags sync edges
module dvp_byte_packer
  import cmos_capture_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vsync,
  input  logic             i_href,
  input  logic [7:0]       i_data,
  output logic             o_pix_stb,
  output logic [PIX_W-1:0] o_pix_data,
  output logic             o_href_rise,
  output logic             o_href_fall,
  output logic             o_vs_rise,
  output logic             o_odd
);

  logic       r_vsync, r_vsync_d, r_href, r_href_d, r_phase;
  logic [7:0] r_data, r_hi;
  logic       w_phase;

  assign o_href_rise = r_href & ~r_href_d;
  assign o_href_fall = ~r_href & r_href_d;
  assign o_vs_rise   = r_vsync & ~r_vsync_d;

  // A new line or frame always restarts on a high byte, whatever was left over.
  assign w_phase   = (o_href_rise | o_vs_rise) ? 1'b0 : r_phase;
  assign o_pix_stb = r_href & w_phase;
  assign o_odd     = o_href_fall & r_phase;

  assign o_pix_data[R_MSB:R_LSB] = r_hi[7:3];
  assign o_pix_data[G_MSB:G_LSB] = {r_hi[2:0], r_data[7:5]};
  assign o_pix_data[B_MSB:B_LSB] = r_data[4:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vsync   <= 1'b0;
      r_vsync_d <= 1'b0;
      r_href    <= 1'b0;
      r_href_d  <= 1'b0;
      r_data    <= 8'h00;
      r_hi      <= 8'h00;
      r_phase   <= 1'b0;
    end else begin
      r_vsync   <= i_vsync;
      r_vsync_d <= r_vsync;
      r_href    <= i_href;
      r_href_d  <= r_href;
      r_data    <= i_data;
      if (r_href) begin
        r_phase <= ~w_phase;
        if (!w_phase) r_hi <= r_data;
      end else begin
        r_phase <= w_phase;
      end
    end
  end

endmodule

// File: rtl/cmos_pixel_capture.sv
// rtl/cmos_pixel_capture.sv - OV5640 DVP capture: frame skipping, x/y tracking, line/frame checks
module cmos_pixel_capture
  import cmos_capture_pkg::*;
#(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 720,
  parameter int SKIP_FRAMES = 10
)
(
  input  logic              I_pxl_clk,
  input  logic              I_rst,
  input  logic              I_cfg_done,
  input  logic              I_vsync,
  input  logic              I_href,
  input  logic [7:0]        I_data,
  output logic              O_pix_valid,
  output logic [PIX_W-1:0]  O_pix_data,
  output logic [CNT_W-1:0]  O_x,
  output logic [CNT_W-1:0]  O_y,
  output logic              O_sof,
  output logic              O_eol,
  output logic              O_active,
  output logic              O_err_line,
  output logic              O_err_frame,
  output logic [FCNT_W-1:0] O_frame_cnt
);

  localparam logic [CNT_W-1:0] LP_H    = CNT_W'(H_RES);
  localparam logic [CNT_W-1:0] LP_V    = CNT_W'(V_RES);
  localparam logic [CNT_W-1:0] LP_EOL  = CNT_W'(H_RES - 1);
  localparam logic [7:0]       LP_SKIP = 8'(SKIP_FRAMES);

  state_t             r_state;
  logic               r_cfg_meta, r_cfg_sync;
  logic [7:0]         r_skip;
  logic [CNT_W-1:0]   r_x, r_y;
  logic               w_pix_stb, w_href_rise, w_href_fall, w_vs_rise, w_odd, w_emit;
  logic [PIX_W-1:0]   w_pix_data;
  logic [CNT_W-1:0]   w_y_next;

  dvp_byte_packer u_packer (
    .i_clk       (I_pxl_clk),
    .i_rst       (I_rst),
    .i_vsync     (I_vsync),
    .i_href      (I_href),
    .i_data      (I_data),
    .o_pix_stb   (w_pix_stb),
    .o_pix_data  (w_pix_data),
    .o_href_rise (w_href_rise),
    .o_href_fall (w_href_fall),
    .o_vs_rise   (w_vs_rise),
    .o_odd       (w_odd)
  );

  // Line count including a line closing in this very cycle, so the frame check sees it.
  assign w_y_next = (w_href_fall && r_y != '1) ? r_y + 1'b1 : r_y;
  assign w_emit   = (r_state == CAPTURE) && w_pix_stb && (r_x < LP_H) && (r_y < LP_V);
  assign O_active = (r_state == CAPTURE);

  always_ff @(posedge I_pxl_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state     <= WAIT_CFG;
      r_cfg_meta  <= 1'b0;
      r_cfg_sync  <= 1'b0;
      r_skip      <= 8'd0;
      r_x         <= '0;
      r_y         <= '0;
      O_pix_valid <= 1'b0;
      O_pix_data  <= '0;
      O_x         <= '0;
      O_y         <= '0;
      O_sof       <= 1'b0;
      O_eol       <= 1'b0;
      O_err_line  <= 1'b0;
      O_err_frame <= 1'b0;
      O_frame_cnt <= '0;
    end else begin
      r_cfg_meta  <= I_cfg_done;
      r_cfg_sync  <= r_cfg_meta;
      O_pix_valid <= 1'b0;
      O_err_line  <= 1'b0;
      O_err_frame <= 1'b0;

      if (w_href_rise) r_x <= '0;
      else if (w_pix_stb && r_x != '1) r_x <= r_x + 1'b1;

      if (w_vs_rise) r_y <= '0;
      else r_y <= w_y_next;

      if (w_emit) begin
        O_pix_valid <= 1'b1;
        O_pix_data  <= w_pix_data;
        O_x         <= r_x;
        O_y         <= r_y;
        O_sof       <= (r_x == '0) && (r_y == '0);
        O_eol       <= (r_x == LP_EOL);
      end

      if (r_state == CAPTURE && w_href_fall)
        O_err_line <= (r_x != LP_H) || w_odd;

      // The vs_rise that moves SKIP->CAPTURE is the unchecked first boundary;
      // every later one closes a captured frame.
      if (!r_cfg_sync) begin
        r_state <= WAIT_CFG;
        r_skip  <= 8'd0;
      end else begin
        case (r_state)
          WAIT_CFG: r_state <= SKIP;
          SKIP: begin
            if (w_vs_rise) begin
              if (r_skip == LP_SKIP) r_state <= CAPTURE;
              else r_skip <= r_skip + 1'b1;
            end
          end
          CAPTURE: begin
            if (w_vs_rise) begin
              O_frame_cnt <= O_frame_cnt + 1'b1;
              O_err_frame <= (w_y_next != LP_V);
            end
          end
          default: r_state <= WAIT_CFG;
        endcase
      end
    end
  end

endmodule
